msrv32_dec_stage: RTL and testbench

Registered, buffered successor to the combinational RV32 decoder: accepts full 32-bit instruction words over a valid/ready handshake, decodes them, and holds decoded control bundles in a parametrised FIFO until the execute stage takes them. It sits between fetch and execute in the msrv32 pipeline. Trap-driven flush is built in, as is a saturating illegal-instruction counter for debug.

---
 rtl/msrv32_dec_stage.sv | 168 ++++++++++++++++
 tb/tb_msrv32_dec_stage.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/msrv32_dec_stage.sv
// msrv32_dec_stage: RV32 instruction decoder with a decoded-bundle FIFO
// between fetch and execute. Trap flush empties the FIFO; a saturating
// counter tracks accepted illegal instructions.
// Optional feature macro: MSRV32_DEC_ZICSR_EN (SYSTEM/CSR decode).
module msrv32_dec_stage #(
  parameter int FIFO_DEPTH = 2,
  parameter int CNT_W      = 8
) (
  input  logic             ms_riscv32_mp_clk_in,
  input  logic             ms_riscv32_mp_rst_n_in,
  input  logic             instr_valid_in,
  output logic             instr_ready_out,
  input  logic [31:0]      instr_in,
  input  logic [1:0]       iadder_1_to_0_in,
  input  logic             trap_taken_in,
  output logic             dec_valid_out,
  input  logic             dec_ready_in,
  output logic [3:0]       alu_opcode_out,
  output logic             mem_wr_req_out,
  output logic [1:0]       load_size_out,
  output logic             load_unsigned_out,
  output logic             rf_wr_en_out,
  output logic [2:0]       imm_type_out,
  output logic [2:0]       csr_op_out,
  output logic             csr_wr_en_out,
  output logic             illegal_instr_out,
  output logic             misaligned_load_out,
  output logic             misaligned_store_out,
  output logic [CNT_W-1:0] illegal_cnt_out
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int BW    = 19;
  localparam logic [PTR_W:0] OCC_FULL = (PTR_W+1)'(FIFO_DEPTH);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       is_lui, is_auipc, is_jal, is_jalr, is_branch, is_load;
  logic       is_store, is_opimm, is_op, is_fence, is_csr;
  logic       dec_illegal, addr_misaligned, dec_mis_load, dec_mis_store;
  logic [2:0] dec_imm_type;
  logic [BW-1:0] dec_bundle, head_bundle;
  logic       unused_instr_bits;

  assign opcode = instr_in[6:0];
  assign funct3 = instr_in[14:12];
  assign unused_instr_bits = ^{instr_in[31], instr_in[29:15], instr_in[11:7]};

  assign is_lui    = (opcode == OPC_LUI);
  assign is_auipc  = (opcode == OPC_AUIPC);
  assign is_jal    = (opcode == OPC_JAL);
  assign is_jalr   = (opcode == OPC_JALR);
  assign is_branch = (opcode == OPC_BRANCH);
  assign is_load   = (opcode == OPC_LOAD);
  assign is_store  = (opcode == OPC_STORE);
  assign is_opimm  = (opcode == OPC_OPIMM);
  assign is_op     = (opcode == OPC_OP);
  assign is_fence  = (opcode == OPC_FENCE);
`ifdef MSRV32_DEC_ZICSR_EN
  assign is_csr    = (opcode == 7'b1110011);
`else
  assign is_csr    = 1'b0;
`endif

  assign dec_illegal = ~(is_lui | is_auipc | is_jal | is_jalr | is_branch | is_load |
                         is_store | is_opimm | is_op | is_fence | is_csr);

  // Word accesses need both low address bits clear, halfwords only bit 0.
  assign addr_misaligned = ((funct3[1:0] == 2'b10) && (iadder_1_to_0_in != 2'b00)) ||
                           ((funct3[1:0] == 2'b01) && iadder_1_to_0_in[0]);
  assign dec_mis_load  = is_load & addr_misaligned;
  assign dec_mis_store = is_store & addr_misaligned;

  // Immediate format selection from the major opcode; R/FENCE/illegal fall to 000.
  always_comb begin
    dec_imm_type = 3'b000;
    if (is_opimm || is_load || is_jalr) dec_imm_type = 3'b001;
    else if (is_store)                  dec_imm_type = 3'b010;
    else if (is_branch)                 dec_imm_type = 3'b011;
    else if (is_lui || is_auipc)        dec_imm_type = 3'b100;
    else if (is_jal)                    dec_imm_type = 3'b101;
    else if (is_csr)                    dec_imm_type = 3'b110;
  end

  // Bundle layout: alu(4) memwr ldsz(2) ldu rfwr imm(3) csrop(3) csrwr ill misld misst
  assign dec_bundle = {
    instr_in[30] & (is_op | (is_opimm & (funct3 == 3'b101))), funct3,
    is_store & ~dec_mis_store & ~dec_illegal,
    is_load ? funct3[1:0] : 2'b00,
    is_load & funct3[2],
    (is_lui | is_auipc | is_jal | is_jalr | is_load | is_opimm | is_op | is_csr) & ~dec_illegal,
    dec_imm_type,
    is_csr ? funct3 : 3'b000,
    is_csr & (funct3 != 3'b000) & (funct3 != 3'b100),
    dec_illegal,
    dec_mis_load,
    dec_mis_store
  };

  logic [BW-1:0]    mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   occ_q, occ_d;
  logic [CNT_W-1:0] illegal_cnt_q, illegal_cnt_d;
  logic             push, pop;

  assign instr_ready_out = (occ_q != OCC_FULL);
  assign dec_valid_out   = (occ_q != '0);
  assign push = instr_valid_in & instr_ready_out & ~trap_taken_in;
  assign pop  = dec_valid_out & dec_ready_in & ~trap_taken_in;

  // Next-state for pointers, occupancy and illegal counter; flush wins over push/pop.
  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    occ_d         = occ_q;
    illegal_cnt_d = illegal_cnt_q;
    if (trap_taken_in) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push && !pop)      occ_d = occ_q + (PTR_W+1)'(1);
      else if (pop && !push) occ_d = occ_q - (PTR_W+1)'(1);
      if (push && dec_illegal && (illegal_cnt_q != {CNT_W{1'b1}}))
        illegal_cnt_d = illegal_cnt_q + CNT_W'(1);
    end
  end

  // Control state register with asynchronous active-low reset.
  always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
    if (!ms_riscv32_mp_rst_n_in) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      occ_q         <= '0;
      illegal_cnt_q <= '0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      occ_q         <= occ_d;
      illegal_cnt_q <= illegal_cnt_d;
    end
  end

  // Bundle storage; contents are only visible while occupancy is nonzero.
  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (push) mem_q[wr_ptr_q] <= dec_bundle;
  end

  assign head_bundle = dec_valid_out ? mem_q[rd_ptr_q] : '0;
  assign {alu_opcode_out, mem_wr_req_out, load_size_out, load_unsigned_out, rf_wr_en_out,
          imm_type_out, csr_op_out, csr_wr_en_out, illegal_instr_out,
          misaligned_load_out, misaligned_store_out} = head_bundle;
  assign illegal_cnt_out = illegal_cnt_q;

endmodule

// File: tb/tb_msrv32_dec_stage.sv
// Scoreboard bench for msrv32_dec_stage: a reference decoder model produces
// expected bundles at push time; a negedge monitor compares the FIFO head.
module tb_msrv32_dec_stage;
  localparam int DEPTH = 2;
  localparam int CW    = 8;
  localparam int CMAX  = (1 << CW) - 1;

  logic clk = 1'b0, rst_n = 1'b0;
  logic instr_valid_in = 1'b0, trap_taken_in = 1'b0, dec_ready_in = 1'b0;
  logic [31:0] instr_in = '0;
  logic [1:0] iadder_1_to_0_in = '0;
  logic instr_ready_out, dec_valid_out, mem_wr_req_out, load_unsigned_out, rf_wr_en_out;
  logic csr_wr_en_out, illegal_instr_out, misaligned_load_out, misaligned_store_out;
  logic [3:0] alu_opcode_out;
  logic [1:0] load_size_out;
  logic [2:0] imm_type_out, csr_op_out;
  logic [CW-1:0] illegal_cnt_out;

  msrv32_dec_stage #(.FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
    .ms_riscv32_mp_clk_in(clk), .ms_riscv32_mp_rst_n_in(rst_n),
    .instr_valid_in(instr_valid_in), .instr_ready_out(instr_ready_out),
    .instr_in(instr_in), .iadder_1_to_0_in(iadder_1_to_0_in),
    .trap_taken_in(trap_taken_in), .dec_valid_out(dec_valid_out),
    .dec_ready_in(dec_ready_in), .alu_opcode_out(alu_opcode_out),
    .mem_wr_req_out(mem_wr_req_out), .load_size_out(load_size_out),
    .load_unsigned_out(load_unsigned_out), .rf_wr_en_out(rf_wr_en_out),
    .imm_type_out(imm_type_out), .csr_op_out(csr_op_out),
    .csr_wr_en_out(csr_wr_en_out), .illegal_instr_out(illegal_instr_out),
    .misaligned_load_out(misaligned_load_out), .misaligned_store_out(misaligned_store_out),
    .illegal_cnt_out(illegal_cnt_out)
  );

  always #5 clk = ~clk;

  int checks = 0, passes = 0;
  logic [18:0] exp_q[$];
  int mcnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Reference decoder: named opcode table, fields assembled per field rules.
  function automatic logic [18:0] model(input logic [31:0] ins, input logic [1:0] ad);
    logic [6:0] op = ins[6:0];
    logic [2:0] f3 = ins[14:12];
    bit legal = 0, ld = 0, st = 0, wr = 0, csr = 0, alu_hi = 0, misl, miss;
    logic [2:0] imm = 3'd0;
    case (op)
      7'b0110111: begin legal = 1; wr = 1; imm = 3'd4; end            // LUI
      7'b0010111: begin legal = 1; wr = 1; imm = 3'd4; end            // AUIPC
      7'b1101111: begin legal = 1; wr = 1; imm = 3'd5; end            // JAL
      7'b1100111: begin legal = 1; wr = 1; imm = 3'd1; end            // JALR
      7'b1100011: begin legal = 1; imm = 3'd3; end                    // BRANCH
      7'b0000011: begin legal = 1; wr = 1; ld = 1; imm = 3'd1; end    // LOAD
      7'b0100011: begin legal = 1; st = 1; imm = 3'd2; end            // STORE
      7'b0010011: begin legal = 1; wr = 1; imm = 3'd1; alu_hi = (f3 == 3'd5) && ins[30]; end
      7'b0110011: begin legal = 1; wr = 1; imm = 3'd0; alu_hi = ins[30]; end
      7'b0001111: begin legal = 1; end                                // FENCE
`ifdef MSRV32_DEC_ZICSR_EN
      7'b1110011: begin legal = 1; wr = 1; csr = 1; imm = 3'd6; end   // SYSTEM
`endif
      default: ;
    endcase
    misl = ld && ((f3[1:0] == 2'd2 && ad != 2'd0) || (f3[1:0] == 2'd1 && ad[0]));
    miss = st && ((f3[1:0] == 2'd2 && ad != 2'd0) || (f3[1:0] == 2'd1 && ad[0]));
    return {alu_hi, f3, st && !miss, ld ? f3[1:0] : 2'd0, ld && f3[2], wr && legal, imm,
            csr ? f3 : 3'd0, csr && f3 != 3'd0 && f3 != 3'd4, !legal, misl, miss};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] r = $urandom;
    case ($urandom_range(0, 11))
      0: r[6:0] = 7'b0110111;   1: r[6:0] = 7'b0010111;   2: r[6:0] = 7'b1101111;
      3: r[6:0] = 7'b1100111;   4: r[6:0] = 7'b1100011;   5: r[6:0] = 7'b0000011;
      6: r[6:0] = 7'b0100011;   7: r[6:0] = 7'b0010011;   8: r[6:0] = 7'b0110011;
      9: r[6:0] = 7'b0001111;  10: r[6:0] = 7'b1110011;
      default: ;
    endcase
    return r;
  endfunction

  // Monitor: compare handshake state, head bundle and counter every cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("dec_valid", {31'd0, dec_valid_out}, {31'd0, exp_q.size() != 0});
      chk("instr_ready", {31'd0, instr_ready_out}, {31'd0, exp_q.size() < DEPTH});
      chk("illegal_cnt", {24'd0, illegal_cnt_out}, mcnt);
      if (dec_valid_out && exp_q.size() != 0) begin
        chk("bundle", {13'd0, dut.head_bundle}, {13'd0, exp_q[0]});
        if (dec_ready_in) void'(exp_q.pop_front());
      end else if (!dec_valid_out) begin
        chk("empty_bundle", {13'd0, alu_opcode_out, mem_wr_req_out, load_size_out,
            load_unsigned_out, rf_wr_en_out, imm_type_out, csr_op_out, csr_wr_en_out,
            illegal_instr_out, misaligned_load_out, misaligned_store_out}, 32'd0);
      end
    end
  end

  // Driver: apply one cycle of stimulus; expectation pushed when the DUT accepts.
  task automatic drive(input bit v, input logic [31:0] ins, input logic [1:0] ad,
                       input bit tr, input bit dr);
    logic [18:0] e;
    instr_valid_in = v; instr_in = ins; iadder_1_to_0_in = ad;
    trap_taken_in = tr; dec_ready_in = dr;
    @(negedge clk); #1;
    if (tr) exp_q.delete();
    else if (v && instr_ready_out) begin
      e = model(ins, ad);
      exp_q.push_back(e);
      if (e[2] && mcnt < CMAX) mcnt++;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", {31'd0, dec_valid_out}, 32'd0);
    chk("rst_ready", {31'd0, instr_ready_out}, 32'd1);
    chk("rst_cnt", {24'd0, illegal_cnt_out}, 32'd0);
    chk("rst_rfwr", {31'd0, rf_wr_en_out}, 32'd0);
    rst_n = 1'b1;

    // ADD
    drive(1, 32'h00B50533, 2'b00, 0, 1);
    chk("add_valid", {31'd0, dec_valid_out}, 32'd1);
    chk("add_alu", {28'd0, alu_opcode_out}, 32'd0);
    chk("add_rfwr", {31'd0, rf_wr_en_out}, 32'd1);
    chk("add_imm", {29'd0, imm_type_out}, 32'd0);
    chk("add_ill", {31'd0, illegal_instr_out}, 32'd0);
    // Misaligned SW
    drive(1, 32'h00B52223, 2'b10, 0, 1);
    chk("sw_mis", {31'd0, misaligned_store_out}, 32'd1);
    chk("sw_memwr", {31'd0, mem_wr_req_out}, 32'd0);
    chk("sw_rfwr", {31'd0, rf_wr_en_out}, 32'd0);
    drive(0, 32'h0, 2'b00, 0, 1);

    // Backpressure with three pushes
    drive(1, 32'h00100093, 2'b00, 0, 0);
    drive(1, 32'h00200113, 2'b00, 0, 0);
    chk("bp_full", {31'd0, instr_ready_out}, 32'd0);
    drive(1, 32'h00300193, 2'b00, 0, 0);
    drive(1, 32'h00300193, 2'b00, 0, 1);
    chk("bp_ready_after_pop", {31'd0, instr_ready_out}, 32'd1);
    drive(1, 32'h00300193, 2'b00, 0, 1);
    drive(0, 32'h0, 2'b00, 0, 1);
    drive(0, 32'h0, 2'b00, 0, 1);

    // Flush with a concurrent push
    drive(1, 32'h00100093, 2'b00, 0, 0);
    drive(1, 32'h00200113, 2'b00, 0, 0);
    drive(1, 32'h00B50533, 2'b00, 1, 0);
    chk("flush_valid", {31'd0, dec_valid_out}, 32'd0);
    chk("flush_ready", {31'd0, instr_ready_out}, 32'd1);
    drive(0, 32'h0, 2'b00, 0, 1);

    // Illegal counter saturation
    for (int i = 0; i < 300; i++) drive(1, 32'hFFFFFFFF, 2'b00, 0, 1);
    chk("ill_flag", {31'd0, illegal_instr_out}, 32'd1);
    chk("ill_rfwr", {31'd0, rf_wr_en_out}, 32'd0);
    chk("ill_cnt_sat", {24'd0, illegal_cnt_out}, 32'd255);
    drive(0, 32'h0, 2'b00, 0, 1);

    // CSRRW
    drive(1, 32'h30529073, 2'b00, 0, 0);
`ifdef MSRV32_DEC_ZICSR_EN
    chk("csr_wr", {31'd0, csr_wr_en_out}, 32'd1);
    chk("csr_op", {29'd0, csr_op_out}, 32'd1);
    chk("csr_ill", {31'd0, illegal_instr_out}, 32'd0);
`else
    chk("csr_ill", {31'd0, illegal_instr_out}, 32'd1);
    chk("csr_wr", {31'd0, csr_wr_en_out}, 32'd0);
`endif
    drive(1, 32'h00100093, 2'b00, 0, 0);

    // Reset mid-operation with the FIFO full
    rst_n = 1'b0; instr_valid_in = 1'b0;
    exp_q.delete(); mcnt = 0;
    #1;
    chk("midrst_valid", {31'd0, dec_valid_out}, 32'd0);
    chk("midrst_ready", {31'd0, instr_ready_out}, 32'd1);
    chk("midrst_cnt", {24'd0, illegal_cnt_out}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Randomized traffic
    for (int i = 0; i < 800; i++)
      drive($urandom_range(0, 3) != 0, rand_instr(), 2'($urandom),
            $urandom_range(0, 30) == 0, $urandom_range(0, 2) != 0);
    for (int i = 0; i < 4; i++) drive(0, 32'h0, 2'b00, 0, 1);
    chk("drained", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
